// File: rtl/max7219_chain_tx.sv
// SPI frame transmitter for a daisy chain of MAX7219 drivers: one CS frame carries a word per device.
// Optional broadcast of the low device word to every slot when MAX7219_BCAST_EN is defined.
module max7219_chain_tx #(
  parameter int N_DEV   = 4,
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
`ifdef MAX7219_BCAST_EN
  input  logic                      bcast,
`endif
  input  logic [N_DEV*WORD_W-1:0]   din,
  output logic                      busy,
  output logic                      finish,
  output logic                      sclk,
  output logic                      mosi,
  output logic                      cs
);

  // state   | meaning
  // S_IDLE  | waiting for start, cs high
  // S_SETUP | cs low, first bit on mosi, sclk low for CLK_DIV cycles
  // S_SHIFT | sclk high/low CLK_DIV cycles each per bit, mosi moves on the fall
  // S_HOLD  | cs low hold after the last bit
  // S_GAP   | cs high latch time, finish issued on the last cycle

  localparam int BITS  = N_DEV * WORD_W;
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP
  } state_t;

  state_t            state, state_nx;
  logic [DIV_W-1:0]  div_cnt, div_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_nx;
  logic [BITS-1:0]   shreg, sh_nx, sh_shift, frame_data;
  logic              sclk_nx, mosi_nx, cs_nx, busy_nx, finish_nx;
  logic              div_done, last_bit;

`ifdef MAX7219_BCAST_EN
  assign frame_data = bcast ? {N_DEV{din[WORD_W-1:0]}} : din;
`else
  assign frame_data = din;
`endif

  assign div_done = (div_cnt == '0);
  assign last_bit = (bit_cnt == '0);
  assign sh_shift = shreg << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs      <= 1'b1;
      busy    <= 1'b0;
      finish  <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      bit_cnt <= bit_nx;
      shreg   <= sh_nx;
      sclk    <= sclk_nx;
      mosi    <= mosi_nx;
      cs      <= cs_nx;
      busy    <= busy_nx;
      finish  <= finish_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_SETUP;
      S_SETUP: if (div_done) state_nx = S_SHIFT;
      S_SHIFT: if (div_done && !sclk && last_bit) state_nx = S_HOLD;
      S_HOLD:  if (div_done) state_nx = S_GAP;
      S_GAP:   if (div_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    div_nx    = div_cnt;
    bit_nx    = bit_cnt;
    sh_nx     = shreg;
    sclk_nx   = sclk;
    mosi_nx   = mosi;
    cs_nx     = cs;
    busy_nx   = busy;
    finish_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          sh_nx   = frame_data;
          mosi_nx = frame_data[BITS-1];
          div_nx  = DIV_LOAD;
          bit_nx  = BIT_LOAD;
          sclk_nx = 1'b0;
          cs_nx   = 1'b0;
          busy_nx = 1'b1;
        end
      end
      S_SETUP: begin
        if (div_done) begin
          div_nx  = DIV_LOAD;
          sclk_nx = 1'b1;
        end else begin
          div_nx = div_cnt - 1'b1;
        end
      end
      S_SHIFT: begin
        if (!div_done) begin
          div_nx = div_cnt - 1'b1;
        end else begin
          div_nx = DIV_LOAD;
          if (sclk) begin
            sclk_nx = 1'b0;
            // last bit stays on mosi through HOLD
            if (!last_bit) begin
              sh_nx   = sh_shift;
              mosi_nx = sh_shift[BITS-1];
            end
          end else if (!last_bit) begin
            sclk_nx = 1'b1;
            bit_nx  = bit_cnt - 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (div_done) begin
          div_nx = DIV_LOAD;
          cs_nx  = 1'b1;
        end else begin
          div_nx = div_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (div_done) begin
          busy_nx   = 1'b0;
          finish_nx = 1'b1;
        end else begin
          div_nx = div_cnt - 1'b1;
        end
      end
      default: begin
        sclk_nx = 1'b0;
        cs_nx   = 1'b1;
        busy_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_max7219_chain_tx.sv
// Directed bench for max7219_chain_tx: frames captured on sclk rises are scored against a queue.
module tb_max7219_chain_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic        bcast = 1'b0;
  logic [31:0] din = '0;
  logic        busy, finish, sclk, mosi, cs;
  logic        busy1, finish1, sclk1, mosi1, cs1;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cap_q[$];
  int          rise_q[$];
  int          blen_q[$];
  int          cslow_q[$];

  logic [31:0] cap;
  int          nrise, blen, cslow;
  logic        sclk_q = 1'b0;
  int          blen1 = 0;
  int          fin1 = 0;

  always #5 clk = ~clk;

  max7219_chain_tx #(.N_DEV(2), .WORD_W(16), .CLK_DIV(2)) u_dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef MAX7219_BCAST_EN
    .bcast(bcast),
`endif
    .din(din), .busy(busy), .finish(finish), .sclk(sclk), .mosi(mosi), .cs(cs)
  );

  max7219_chain_tx #(.N_DEV(2), .WORD_W(16), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef MAX7219_BCAST_EN
    .bcast(bcast),
`endif
    .din(din), .busy(busy1), .finish(finish1), .sclk(sclk1), .mosi(mosi1), .cs(cs1)
  );

  // frame monitor: mosi sampled where sclk has just risen
  always @(negedge clk) begin
    if (rst) begin
      cap = '0; nrise = 0; blen = 0; cslow = 0;
    end else begin
      if (sclk && !sclk_q) begin
        cap = {cap[30:0], mosi};
        nrise++;
      end
      if (busy) blen++;
      if (!cs) cslow++;
      if (finish) begin
        cap_q.push_back(cap);
        rise_q.push_back(nrise);
        blen_q.push_back(blen);
        cslow_q.push_back(cslow);
        cap = '0; nrise = 0; blen = 0; cslow = 0;
      end
    end
    sclk_q = sclk;
    if (busy1) blen1++;
    if (finish1) fin1++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] expect_word);
    din = d;
    start = 1'b1;
    exp_q.push_back(expect_word);
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int cyc;
    cyc = 0;
    while (cap_q.size() == 0 && cyc < 400) begin
      step(1);
      cyc++;
    end
    chk({tag, "_timeout"}, 64'(cap_q.size() != 0), 64'd1);
    step(1);
  endtask

  task automatic compare_frame(input string tag);
    if (cap_q.size() == 0 || exp_q.size() == 0) begin
      chk({tag, "_missing"}, 64'(cap_q.size()), 64'(exp_q.size() + 1));
    end else begin
      chk({tag, "_data"},  64'(cap_q.pop_front()),   64'(exp_q.pop_front()));
      chk({tag, "_rises"}, 64'(rise_q.pop_front()),  64'd32);
      chk({tag, "_busy"},  64'(blen_q.pop_front()),  64'd134);
      chk({tag, "_cslow"}, 64'(cslow_q.pop_front()), 64'd132);
    end
  endtask

  initial begin
    int nf, cyc, busy_low, cs_run, min_run;

    // 1: reset behaviour
    for (int i = 0; i < 4; i++) begin
      step(1);
      chk("reset_out", 64'({cs, sclk, mosi, busy, finish}), 64'b10000);
    end
    rst = 1'b0;
    step(3);
    chk("idle_out", 64'({cs, sclk, mosi, busy, finish}), 64'b10000);

    // 2: single frame
    send(32'hAAAA_0A0A, 32'hAAAA_0A0A);
    chk("accept_out", 64'({cs, sclk, mosi, busy}), 64'b0011);
    wait_frame("f2");
    chk("finish_width", 64'(finish), 64'd0);
    compare_frame("f2");

    // 3: start re-pulsed mid-frame is ignored
    send(32'hAAAA_0A0A, 32'hAAAA_0A0A);
    step(40);
    din = 32'h1234_5678;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_frame("f3");
    compare_frame("f3");
    step(20);
    chk("f3_no_extra", 64'(cap_q.size()), 64'd0);
    chk("f3_idle_busy", 64'(busy), 64'd0);

    // 4: start held high -> back-to-back frames
    din = 32'h1234_5678;
    start = 1'b1;
    for (int i = 0; i < 3; i++) exp_q.push_back(32'h1234_5678);
    nf = 0; cyc = 0; busy_low = 0; cs_run = 0; min_run = 1000;
    while (nf < 3 && cyc < 2000) begin
      step(1);
      cyc++;
      if (finish) nf++;
      if (nf >= 1 && nf < 3 && !busy) busy_low++;
      if (cs) cs_run++;
      else begin
        if (cs_run > 0 && nf >= 1 && cs_run < min_run) min_run = cs_run;
        cs_run = 0;
      end
    end
    start = 1'b0;
    chk("b2b_count", 64'(nf), 64'd3);
    chk("b2b_busy_low", 64'(busy_low), 64'd2);
    chk("b2b_cs_gap_ge2", 64'(min_run >= 2 && min_run < 1000), 64'd1);
    step(3);
    chk("b2b_stopped", 64'(busy), 64'd0);
    for (int i = 0; i < 3; i++) compare_frame("b2b");

    // 5: reset mid-frame
    send(32'hC3C3_5A5A, 32'h0);
    void'(exp_q.pop_back());
    cyc = 0;
    while (nrise < 22 && cyc < 400) begin
      step(1);
      cyc++;
    end
    chk("abort_reach", 64'(nrise >= 22), 64'd1);
    rst = 1'b1;
    step(1);
    chk("abort_out", 64'({cs, sclk, busy, finish}), 64'b1000);
    rst = 1'b0;
    step(3);
    chk("abort_no_finish", 64'(cap_q.size()), 64'd0);
    send(32'h0F0F_F0F0, 32'h0F0F_F0F0);
    wait_frame("f5");
    compare_frame("f5");

    // 6: broadcast (or plain pass-through in the default build)
`ifdef MAX7219_BCAST_EN
    bcast = 1'b1;
    send(32'hFFFF_0C01, 32'h0C01_0C01);
    bcast = 1'b0;
`else
    send(32'hFFFF_0C01, 32'hFFFF_0C01);
`endif
    wait_frame("f6");
    compare_frame("f6");

    // CLK_DIV=1 instance: busy length
    blen1 = 0;
    fin1 = 0;
    din = 32'h5555_AAAA;
    start1 = 1'b1;
    step(1);
    start1 = 1'b0;
    cyc = 0;
    while (fin1 == 0 && cyc < 300) begin
      step(1);
      cyc++;
    end
    step(5);
    chk("div1_busy", 64'(blen1), 64'd67);
    chk("div1_finish", 64'(fin1), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
